// File: rtl/receiver_vna_pkg.sv
// receiver_vna_pkg
// Shared definitions for the VNA scan receiver:
//   vna_state_t      scan controller states
//   *_cycle()        slot-phase offsets within one DECIMATION-long slot,
//                    derived from DECIMATION and N = 2**ACC_LOG2
// The zero-marker feature is selected by the VNA_ZERO_MARKER_EN macro and
// is resolved in receiver_vna_scan.
package receiver_vna_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PC_SCAN = 3'd1,
    ST_SYNC    = 3'd2,
    ST_SLOT    = 3'd3,
    ST_DONE    = 3'd4
  } vna_state_t;

  // First slot cycle whose cordic sample enters the accumulator.
  function automatic int acc_first_cycle(input int decimation, input int acc_log2);
    return decimation - 2 - (1 << acc_log2);
  endfunction

  // Last slot cycle whose cordic sample enters the accumulator.
  function automatic int acc_last_cycle(input int decimation);
    return decimation - 3;
  endfunction

  // Slot cycle on which the scaled accumulator is copied to the outputs.
  function automatic int out_load_cycle(input int decimation);
    return decimation - 2;
  endfunction

  // Final slot cycle; output_strobe is high during it.
  function automatic int slot_last_cycle(input int decimation);
    return decimation - 1;
  endfunction

endpackage

// File: rtl/receiver_vna_scan_accum.sv
// vna_accum
// One channel of the VNA averager: I and Q sample accumulators plus the
// truncating scale to the output width.
// Ports:
//   clock, rst_n          clock, synchronous active-low reset
//   clear                 zero both accumulators (slot start / scan abort)
//   enable                add the current samples
//   load                  copy the scaled accumulators to the outputs
//   zero                  with load: output zero instead (marker slot)
//   sample_inphase/quad   signed cordic samples, IN_W bits
//   avg_inphase/quad      averaged outputs, OUT_W bits, held between loads
module vna_accum
  import receiver_vna_pkg::*;
#(
  parameter int IN_W     = 18,
  parameter int OUT_W    = 24,
  parameter int ACC_LOG2 = 10
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             load,
  input  logic             zero,
  input  logic [IN_W-1:0]  sample_inphase,
  input  logic [IN_W-1:0]  sample_quad,
  output logic [OUT_W-1:0] avg_inphase,
  output logic [OUT_W-1:0] avg_quad
);

  localparam int ACC_W = IN_W + ACC_LOG2;

  // Two's-complement sums wrap identically whether viewed as signed or not,
  // so explicit sign extension plus unsigned addition is enough.
  logic [ACC_W-1:0] acc_inphase_reg;
  logic [ACC_W-1:0] acc_quad_reg;
  logic [ACC_W-1:0] ext_inphase;
  logic [ACC_W-1:0] ext_quad;

  assign ext_inphase = {{ACC_LOG2{sample_inphase[IN_W-1]}}, sample_inphase};
  assign ext_quad    = {{ACC_LOG2{sample_quad[IN_W-1]}}, sample_quad};

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      acc_inphase_reg <= '0;
      acc_quad_reg    <= '0;
      avg_inphase     <= '0;
      avg_quad        <= '0;
    end else begin
      if (clear) begin
        acc_inphase_reg <= '0;
        acc_quad_reg    <= '0;
      end else if (enable) begin
        acc_inphase_reg <= acc_inphase_reg + ext_inphase;
        acc_quad_reg    <= acc_quad_reg + ext_quad;
      end
      if (load) begin
        // Keep the top OUT_W bits: divide by 2**(ACC_W-OUT_W), truncating.
        avg_inphase <= zero ? '0 : acc_inphase_reg[ACC_W-1 -: OUT_W];
        avg_quad    <= zero ? '0 : acc_quad_reg[ACC_W-1 -: OUT_W];
      end
    end
  end

endmodule

// File: rtl/receiver_vna_scan.sv
// receiver_vna_scan
// VNA scan controller and per-channel I/Q averager. In PC-scan mode
// (vna_count == 0) the Tx frequency simply follows tx_freq_in. In FPGA-scan
// mode the block steps the Tx frequency through vna_count points, one point
// per DECIMATION-clock slot, averaging 2**ACC_LOG2 cordic samples per slot
// and pulsing output_strobe once per slot.
// Optional feature: define VNA_ZERO_MARKER_EN to prefix every scan with one
// marker slot whose outputs are all zero.
// Ports:
//   clock, rst_n          clock, synchronous active-low reset
//   vna                   scan enable; 0 forces IDLE
//   repeat_scan           restart after the last point (else stop in DONE)
//   vna_count             points per scan, 0 = PC-scan
//   freq_delta            frequency step per point
//   tx_freq_in            start (FPGA-scan) or live (PC-scan) frequency
//   cordic_i, cordic_q    NCH packed signed samples, channel 0 in LSBs
//   tx_freq_out           frequency to the Tx NCO
//   out_i, out_q          NCH packed averaged samples, channel 0 in LSBs
//   output_strobe         one-cycle pulse, outputs valid on that cycle
//   scan_done             high while the finished scan waits in DONE
module receiver_vna_scan
  import receiver_vna_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int IN_W       = 18,
  parameter int OUT_W      = 24,
  parameter int ACC_LOG2   = 10,
  parameter int DECIMATION = 7680
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 vna,
  input  logic                 repeat_scan,
  input  logic [15:0]          vna_count,
  input  logic [31:0]          freq_delta,
  input  logic [31:0]          tx_freq_in,
  input  logic [NCH*IN_W-1:0]  cordic_i,
  input  logic [NCH*IN_W-1:0]  cordic_q,
  output logic [31:0]          tx_freq_out,
  output logic [NCH*OUT_W-1:0] out_i,
  output logic [NCH*OUT_W-1:0] out_q,
  output logic                 output_strobe,
  output logic                 scan_done
);

`ifdef VNA_ZERO_MARKER_EN
  localparam int MARKER_SLOTS = 1;
`else
  localparam int MARKER_SLOTS = 0;
`endif

  localparam int N     = 1 << ACC_LOG2;
  localparam int CNT_W = $clog2(DECIMATION);

  localparam logic [CNT_W-1:0] ACC_FIRST = CNT_W'(acc_first_cycle(DECIMATION, ACC_LOG2));
  localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(acc_last_cycle(DECIMATION));
  localparam logic [CNT_W-1:0] OUT_LOAD  = CNT_W'(out_load_cycle(DECIMATION));
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(slot_last_cycle(DECIMATION));

  // Parameter sanity: the accumulation window must fit after slot cycle 0.
  if (DECIMATION < N + 4) begin : g_bad_decimation
    $error("receiver_vna_scan: DECIMATION must be >= 2**ACC_LOG2 + 4");
  end
  if (OUT_W > IN_W + ACC_LOG2) begin : g_bad_out_w
    $error("receiver_vna_scan: OUT_W must be <= IN_W + ACC_LOG2");
  end
  if (NCH < 1 || NCH > 4) begin : g_bad_nch
    $error("receiver_vna_scan: NCH must be in 1..4");
  end

  vna_state_t       state_reg, state_next;
  logic [CNT_W-1:0] slot_cnt_reg, slot_cnt_next;
  logic [16:0]      slot_idx_reg, slot_idx_next;
  logic [15:0]      count_reg, count_next;
  logic [31:0]      start_reg, start_next;
  logic [31:0]      delta_reg, delta_next;
  logic [31:0]      tx_freq_next;
  logic             strobe_next;

  logic [16:0] last_slot;
  logic        is_marker;
  logic        first_point;
  logic        in_slot;
  logic        acc_clear;
  logic        acc_enable;
  logic        out_load;

  // Slot index counts the marker (if present) as slot 0.
  assign last_slot   = {1'b0, count_reg} + 17'(MARKER_SLOTS) - 17'd1;
  assign is_marker   = (MARKER_SLOTS != 0) && (slot_idx_reg == 17'd0);
  assign first_point = (slot_idx_reg == 17'(MARKER_SLOTS));
  assign in_slot     = vna && (state_reg == ST_SLOT);

  assign acc_clear  = !in_slot || (slot_cnt_reg == '0);
  assign acc_enable = in_slot && !is_marker &&
                      (slot_cnt_reg >= ACC_FIRST) && (slot_cnt_reg <= ACC_LAST);
  assign out_load   = in_slot && (slot_cnt_reg == OUT_LOAD);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    slot_cnt_next = slot_cnt_reg;
    slot_idx_next = slot_idx_reg;
    count_next    = count_reg;
    start_next    = start_reg;
    delta_next    = delta_reg;
    tx_freq_next  = tx_freq_out;
    strobe_next   = 1'b0;

    if (!vna) begin
      // Dropping vna aborts whatever is in progress.
      state_next    = ST_IDLE;
      tx_freq_next  = tx_freq_in;
      slot_cnt_next = '0;
      slot_idx_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          count_next   = vna_count;
          start_next   = tx_freq_in;
          delta_next   = freq_delta;
          tx_freq_next = tx_freq_in;
          state_next   = (vna_count == 16'd0) ? ST_PC_SCAN : ST_SYNC;
        end
        ST_PC_SCAN: begin
          tx_freq_next = tx_freq_in;
        end
        ST_SYNC: begin
          // Zero frequency for one cycle resets the NCO phase accumulator.
          tx_freq_next  = '0;
          slot_cnt_next = '0;
          slot_idx_next = '0;
          state_next    = ST_SLOT;
        end
        ST_SLOT: begin
          if (slot_cnt_reg == '0) begin
            tx_freq_next = (is_marker || first_point) ? start_reg : tx_freq_out + delta_reg;
          end
          // Registered strobe lands on the last slot cycle.
          if (slot_cnt_reg == OUT_LOAD) begin
            strobe_next = 1'b1;
          end
          if (slot_cnt_reg == SLOT_LAST) begin
            slot_cnt_next = '0;
            if (slot_idx_reg == last_slot) begin
              slot_idx_next = '0;
              if (repeat_scan) begin
                count_next = vna_count;
                start_next = tx_freq_in;
                delta_next = freq_delta;
                state_next = (vna_count == 16'd0) ? ST_PC_SCAN : ST_SYNC;
              end else begin
                state_next = ST_DONE;
              end
            end else begin
              slot_idx_next = slot_idx_reg + 17'd1;
            end
          end else begin
            slot_cnt_next = slot_cnt_reg + CNT_W'(1);
          end
        end
        ST_DONE: begin
          // Hold everything until vna falls.
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      slot_cnt_reg  <= '0;
      slot_idx_reg  <= '0;
      count_reg     <= '0;
      start_reg     <= '0;
      delta_reg     <= '0;
      tx_freq_out   <= '0;
      output_strobe <= 1'b0;
    end else begin
      slot_cnt_reg  <= slot_cnt_next;
      slot_idx_reg  <= slot_idx_next;
      count_reg     <= count_next;
      start_reg     <= start_next;
      delta_reg     <= delta_next;
      tx_freq_out   <= tx_freq_next;
      output_strobe <= strobe_next;
    end
  end

  assign scan_done = (state_reg == ST_DONE);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    vna_accum #(
      .IN_W     (IN_W),
      .OUT_W    (OUT_W),
      .ACC_LOG2 (ACC_LOG2)
    ) u_accum (
      .clock          (clock),
      .rst_n          (rst_n),
      .clear          (acc_clear),
      .enable         (acc_enable),
      .load           (out_load),
      .zero           (is_marker),
      .sample_inphase (cordic_i[gi*IN_W +: IN_W]),
      .sample_quad    (cordic_q[gi*IN_W +: IN_W]),
      .avg_inphase    (out_i[gi*OUT_W +: OUT_W]),
      .avg_quad       (out_q[gi*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_receiver_vna_scan.sv
// tb_receiver_vna_scan
// Directed sequence with random cordic data for receiver_vna_scan. Expected
// averages come from a history of the samples driven each cycle: each
// strobe's value is the truncated sum of the N samples presented 2..N+1
// cycles before the strobe. Frequencies are start + point*delta (mod 2**32).
module tb_receiver_vna_scan;

  localparam int NCH      = 2;
  localparam int IN_W     = 18;
  localparam int OUT_W    = 20;
  localparam int ACC_LOG2 = 4;
  localparam int DEC      = 24;
  localparam int N        = 1 << ACC_LOG2;
  localparam int SHIFT    = IN_W + ACC_LOG2 - OUT_W;
  localparam int HN       = 64;
`ifdef VNA_ZERO_MARKER_EN
  localparam int MARKER = 1;
`else
  localparam int MARKER = 0;
`endif

  logic                 clock = 1'b0;
  logic                 rst_n;
  logic                 vna;
  logic                 repeat_scan;
  logic [15:0]          vna_count;
  logic [31:0]          freq_delta;
  logic [31:0]          tx_freq_in;
  logic [NCH*IN_W-1:0]  cordic_i;
  logic [NCH*IN_W-1:0]  cordic_q;
  logic [31:0]          tx_freq_out;
  logic [NCH*OUT_W-1:0] out_i;
  logic [NCH*OUT_W-1:0] out_q;
  logic                 output_strobe;
  logic                 scan_done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int smode = 0;  // 0 = random samples, 1 = fixed samples

  logic signed [IN_W-1:0] fix_i [NCH];
  logic signed [IN_W-1:0] fix_q [NCH];
  logic signed [IN_W-1:0] hist_i [NCH][HN];
  logic signed [IN_W-1:0] hist_q [NCH][HN];

  always #5 clock = ~clock;

  receiver_vna_scan #(
    .NCH        (NCH),
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .ACC_LOG2   (ACC_LOG2),
    .DECIMATION (DEC)
  ) dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .vna           (vna),
    .repeat_scan   (repeat_scan),
    .vna_count     (vna_count),
    .freq_delta    (freq_delta),
    .tx_freq_in    (tx_freq_in),
    .cordic_i      (cordic_i),
    .cordic_q      (cordic_q),
    .tx_freq_out   (tx_freq_out),
    .out_i         (out_i),
    .out_q         (out_q),
    .output_strobe (output_strobe),
    .scan_done     (scan_done)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive_samples();
    for (int c = 0; c < NCH; c++) begin
      logic signed [IN_W-1:0] si;
      logic signed [IN_W-1:0] sq;
      if (smode == 0) begin
        si = IN_W'($urandom);
        sq = IN_W'($urandom);
      end else begin
        si = fix_i[c];
        sq = fix_q[c];
      end
      cordic_i[c*IN_W +: IN_W] = si;
      cordic_q[c*IN_W +: IN_W] = sq;
      hist_i[c][cyc % HN] = si;
      hist_q[c][cyc % HN] = sq;
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    drive_samples();
  endtask

  function automatic logic [NCH*OUT_W-1:0] exp_avg(input bit quad, input int t);
    logic [NCH*OUT_W-1:0] r;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      longint s;
      int     idx;
      s = 0;
      for (int k = 2; k <= N + 1; k++) begin
        idx = (((t - k) % HN) + HN) % HN;
        s += quad ? longint'(hist_q[c][idx]) : longint'(hist_i[c][idx]);
      end
      s = s >>> SHIFT;
      r[c*OUT_W +: OUT_W] = s[OUT_W-1:0];
    end
    return r;
  endfunction

  task automatic run_scan(input int cnt, input logic [31:0] start, input logic [31:0] delta,
                          input bit rep, input int nstrobes, input string tag);
    int          j;
    int          last_t;
    int          zeros;
    int          budget;
    int          slot;
    int          point;
    logic [31:0] efreq;
    vna         = 1'b0;
    tx_freq_in  = start;
    vna_count   = 16'(cnt);
    freq_delta  = delta;
    repeat_scan = rep;
    step();
    step();
    vna    = 1'b1;
    last_t = cyc;
    j      = 0;
    zeros  = 0;
    budget = (nstrobes + 2) * (DEC + 2);
    while (j < nstrobes && budget > 0) begin
      step();
      budget--;
      if (j == 0 && tx_freq_out == 32'd0) zeros++;
      if (output_strobe) begin
        slot  = j % (cnt + MARKER);
        point = slot - MARKER;
        efreq = (point < 0) ? start : start + delta * 32'(point);
        check({tag, " gap"}, 64'(cyc - last_t), 64'((slot == 0) ? DEC + 1 : DEC));
        check({tag, " freq"}, 64'(tx_freq_out), 64'(efreq));
        check({tag, " out_i"}, 64'(out_i), (point < 0) ? 64'd0 : 64'(exp_avg(1'b0, cyc)));
        check({tag, " out_q"}, 64'(out_q), (point < 0) ? 64'd0 : 64'(exp_avg(1'b1, cyc)));
        $display("[TB] %s strobe %0d at cycle %0d freq=%0h out_i=%0h out_q=%0h",
                 tag, j, cyc, tx_freq_out, out_i, out_q);
        last_t = cyc;
        j++;
      end
    end
    check({tag, " strobe_count"}, 64'(j), 64'(nstrobes));
    check({tag, " sync_zero_cycles"}, 64'(zeros), 64'd1);
  endtask

  task automatic check_done(input logic [31:0] efreq, input string tag);
    int strobes;
    int low;
    strobes = 0;
    low     = 0;
    step();
    check({tag, " scan_done"}, 64'(scan_done), 64'd1);
    check({tag, " done_freq"}, 64'(tx_freq_out), 64'(efreq));
    for (int k = 0; k < 2 * DEC; k++) begin
      step();
      if (output_strobe) strobes++;
      if (!scan_done) low++;
    end
    check({tag, " done_strobes"}, 64'(strobes), 64'd0);
    check({tag, " done_low"}, 64'(low), 64'd0);
    check({tag, " done_freq_hold"}, 64'(tx_freq_out), 64'(efreq));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          strobes;
    int          busy;
    logic [31:0] rs;
    logic [31:0] rd;

    // Reset, with vna asserted to show reset takes priority.
    rst_n       = 1'b0;
    vna         = 1'b1;
    repeat_scan = 1'b0;
    vna_count   = 16'd3;
    freq_delta  = 32'd10;
    tx_freq_in  = 32'd1000;
    fix_i[0] = '0; fix_i[1] = '0; fix_q[0] = '0; fix_q[1] = '0;
    drive_samples();
    strobes = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (output_strobe) strobes++;
    end
    check("reset tx_freq_out", 64'(tx_freq_out), 64'd0);
    check("reset out_i", 64'(out_i), 64'd0);
    check("reset out_q", 64'(out_q), 64'd0);
    check("reset strobe", 64'(strobes), 64'd0);
    check("reset scan_done", 64'(scan_done), 64'd0);

    vna   = 1'b0;
    rst_n = 1'b1;
    check("release same cycle", 64'(tx_freq_out), 64'd0);
    step();
    check("release tx_freq_out", 64'(tx_freq_out), 64'd1000);
    $display("[TB] reset released, tx_freq_out=%0d", tx_freq_out);
    strobes = 0;
    for (int k = 0; k < DEC + 4; k++) begin
      step();
      if (output_strobe) strobes++;
    end
    check("idle strobes", 64'(strobes), 64'd0);

    // PC-scan: frequency tracks the input one cycle later.
    vna_count  = 16'd0;
    tx_freq_in = 32'd5;
    vna        = 1'b1;
    step();
    check("pc first freq", 64'(tx_freq_out), 64'd5);
    for (int v = 6; v <= 9; v++) begin
      tx_freq_in = 32'(v);
      step();
      check("pc follow", 64'(tx_freq_out), 64'(v));
      $display("[TB] pc-scan tx_freq_in=%0d tx_freq_out=%0d", v, tx_freq_out);
    end
    vna_count = 16'd3;
    strobes   = 0;
    busy      = 0;
    for (int k = 0; k < 2 * DEC + 4; k++) begin
      step();
      if (output_strobe) strobes++;
      if (scan_done) busy++;
    end
    check("pc strobes", 64'(strobes), 64'd0);
    check("pc scan_done", 64'(busy), 64'd0);
    check("pc hold freq", 64'(tx_freq_out), 64'd9);

    // All-ones input: N / 2**SHIFT per channel.
    smode = 1;
    for (int c = 0; c < NCH; c++) begin
      fix_i[c] = 18'sd1;
      fix_q[c] = 18'sd1;
    end
    run_scan(3, 32'd100, 32'd10, 1'b0, 3 + MARKER, "basic");
    check_done(32'd120, "basic");
    check("basic literal out_i", 64'(out_i), {24'd0, 20'd4, 20'd4});

    // Full-scale opposite polarities on the two channels.
    fix_i[0] = 18'sh20000;
    fix_i[1] = 18'sh1FFFF;
    fix_q[0] = 18'sh1FFFF;
    fix_q[1] = 18'sh20000;
    run_scan(2, 32'd500, 32'd7, 1'b0, 2 + MARKER, "extreme");
    check_done(32'd507, "extreme");
    check("extreme literal out_i", 64'(out_i), {24'd0, 20'h7FFFC, 20'h80000});
    check("extreme literal out_q", 64'(out_q), {24'd0, 20'h80000, 20'h7FFFC});

    // Random data, random frequency plan.
    smode = 0;
    rs = $urandom | 32'd1;
    rd = $urandom;
    run_scan(4, rs, rd, 1'b0, 4 + MARKER, "random");
    check_done(rs + 32'd3 * rd, "random");

    // Abort during accumulation, then a clean restart.
    vna_count   = 16'd3;
    freq_delta  = 32'd5;
    tx_freq_in  = 32'd300;
    repeat_scan = 1'b0;
    vna         = 1'b1;
    strobes     = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (output_strobe) strobes++;
    end
    check("abort early strobes", 64'(strobes), 64'd0);
    vna        = 1'b0;
    tx_freq_in = 32'd777;
    step();
    check("abort freq", 64'(tx_freq_out), 64'd777);
    check("abort strobe", 64'(output_strobe), 64'd0);
    check("abort scan_done", 64'(scan_done), 64'd0);
    strobes = 0;
    for (int k = 0; k < DEC + 4; k++) begin
      step();
      if (output_strobe) strobes++;
    end
    check("abort idle strobes", 64'(strobes), 64'd0);
    run_scan(3, 32'd300, 32'd5, 1'b0, 3 + MARKER, "restart");
    check_done(32'd310, "restart");

    // Repeat mode: one point per scan, a SYNC cycle between scans.
    run_scan(1, 32'hFFFF_FFF0, 32'h20, 1'b1, 3 * (1 + MARKER), "repeat");
    // Frequency wrap-around across the 32-bit boundary.
    run_scan(2, 32'hFFFF_FFF0, 32'h20, 1'b0, 2 + MARKER, "wrap");
    check_done(32'h0000_0010, "wrap");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
